// File: rtl/status_flags.sv
// 6502 processor status register with flag instructions, PLP/RTI pull and interrupt front end.
// Optional set-overflow pin and its synchroniser are built only when SO_PIN_EN is defined.
module status_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_v,
  input  logic       upd_c,
  input  logic [2:0] flag_op,
  input  logic       pull,
  input  logic [7:0] db_in,
  input  logic       sync,
  input  logic       int_ack,
  input  logic       push_b,
  input  logic       irq_n,
  input  logic       nmi_n,
`ifdef SO_PIN_EN
  input  logic       so_n,
`endif
  output logic [7:0] p_out,
  output logic       c,
  output logic       d,
  output logic       int_req,
  output logic       nmi_sel
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLC  = 3'd1,
    OP_SEC  = 3'd2,
    OP_CLI  = 3'd3,
    OP_SEI  = 3'd4,
    OP_CLD  = 3'd5,
    OP_SED  = 3'd6,
    OP_CLV  = 3'd7
  } flagOp_e;

  flagOp_e opSel;
  logic nFlag_q, vFlag_q, dFlag_q, iFlag_q, zFlag_q, cFlag_q;
  logic nFlag_d, vFlag_d, dFlag_d, iFlag_d, zFlag_d, cFlag_d;
  logic iPoll_q, iPoll_d;
  logic nmiPend_q, nmiPend_d;
  logic irqS1_q, irqS2_q;
  logic nmiS1_q, nmiS2_q, nmiS3_q;
  logic nmiEdge;
  logic unusedDbBits;

  assign opSel        = flagOp_e'(flag_op);
  assign nmiEdge      = ~nmiS2_q & nmiS3_q;
  assign unusedDbBits = ^db_in[5:4];

`ifdef SO_PIN_EN
  logic soS1_q, soS2_q, soS3_q;
  logic soEdge;

  assign soEdge = ~soS2_q & soS3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      soS1_q <= 1'b1;
      soS2_q <= 1'b1;
      soS3_q <= 1'b1;
    end else begin
      soS1_q <= so_n;
      soS2_q <= soS1_q;
      soS3_q <= soS2_q;
    end
  end
`endif

  // Sources are applied lowest priority first so later assignments win.
  always_comb begin
    nFlag_d   = nFlag_q;
    vFlag_d   = vFlag_q;
    dFlag_d   = dFlag_q;
    iFlag_d   = iFlag_q;
    zFlag_d   = zFlag_q;
    cFlag_d   = cFlag_q;
    iPoll_d   = iPoll_q;
    nmiPend_d = nmiPend_q;

    if (upd_nz) begin
      nFlag_d = alu_n;
      zFlag_d = alu_z;
    end
    if (upd_v) vFlag_d = alu_v;
    if (upd_c) cFlag_d = alu_c;
`ifdef SO_PIN_EN
    if (soEdge) vFlag_d = 1'b1;
`endif
    case (opSel)
      OP_CLC:  cFlag_d = 1'b0;
      OP_SEC:  cFlag_d = 1'b1;
      OP_CLI:  iFlag_d = 1'b0;
      OP_SEI:  iFlag_d = 1'b1;
      OP_CLD:  dFlag_d = 1'b0;
      OP_SED:  dFlag_d = 1'b1;
      OP_CLV:  vFlag_d = 1'b0;
      default: ;
    endcase
    if (pull) begin
      nFlag_d = db_in[7];
      vFlag_d = db_in[6];
      dFlag_d = db_in[3];
      iFlag_d = db_in[2];
      zFlag_d = db_in[1];
      cFlag_d = db_in[0];
    end
    if (int_ack) iFlag_d = 1'b1;

    // The poll copy lags I by one instruction boundary; RTI restores it at once.
    if (sync) iPoll_d = iFlag_q;
    if (pull) iPoll_d = db_in[2];

    if (int_ack) nmiPend_d = 1'b0;
    if (nmiEdge) nmiPend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nFlag_q   <= 1'b0;
      vFlag_q   <= 1'b0;
      dFlag_q   <= 1'b0;
      iFlag_q   <= 1'b1;
      zFlag_q   <= 1'b0;
      cFlag_q   <= 1'b0;
      iPoll_q   <= 1'b1;
      nmiPend_q <= 1'b0;
      irqS1_q   <= 1'b1;
      irqS2_q   <= 1'b1;
      nmiS1_q   <= 1'b1;
      nmiS2_q   <= 1'b1;
      nmiS3_q   <= 1'b1;
    end else begin
      nFlag_q   <= nFlag_d;
      vFlag_q   <= vFlag_d;
      dFlag_q   <= dFlag_d;
      iFlag_q   <= iFlag_d;
      zFlag_q   <= zFlag_d;
      cFlag_q   <= cFlag_d;
      iPoll_q   <= iPoll_d;
      nmiPend_q <= nmiPend_d;
      irqS1_q   <= irq_n;
      irqS2_q   <= irqS1_q;
      nmiS1_q   <= nmi_n;
      nmiS2_q   <= nmiS1_q;
      nmiS3_q   <= nmiS2_q;
    end
  end

  assign p_out   = {nFlag_q, vFlag_q, 1'b1, push_b, dFlag_q, iFlag_q, zFlag_q, cFlag_q};
  assign c       = cFlag_q;
  assign d       = dFlag_q;
  assign int_req = nmiPend_q | (~irqS2_q & ~iPoll_q);
  assign nmi_sel = nmiPend_q;

endmodule

// File: tb/tb_status_flags.sv
// Randomised scoreboard bench for status_flags against a byte-level model of the P register.
// Exercises the set-overflow pin too when SO_PIN_EN is defined.
module tb_status_flags;

  typedef struct packed {
    logic       rstN;
    logic       aluN;
    logic       aluV;
    logic       aluZ;
    logic       aluC;
    logic       updNz;
    logic       updV;
    logic       updC;
    logic [2:0] flagOp;
    logic       pull;
    logic [7:0] db;
    logic       sync;
    logic       intAck;
    logic       pushB;
    logic       irqN;
    logic       nmiN;
    logic       soN;
  } stim_t;

  logic       clk;
  logic       rst_n;
  logic       alu_n, alu_v, alu_z, alu_c;
  logic       upd_nz, upd_v, upd_c;
  logic [2:0] flag_op;
  logic       pull;
  logic [7:0] db_in;
  logic       sync, int_ack, push_b;
  logic       irq_n, nmi_n, so_n;
  logic [7:0] p_out;
  logic       c, d, int_req, nmi_sel;

  int total = 0;
  int bad = 0;
  int cycleNo = 0;
  logic [11:0] expQ[$];

  logic [7:0] mP;
  logic       mIPoll;
  logic       mNmiPend;
  logic       irqHist[$];
  logic       nmiHist[$];
  logic       soHist[$];
  logic       irqLvl, nmiLvl, soLvl;

  status_flags dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_n(alu_n),
    .alu_v(alu_v),
    .alu_z(alu_z),
    .alu_c(alu_c),
    .upd_nz(upd_nz),
    .upd_v(upd_v),
    .upd_c(upd_c),
    .flag_op(flag_op),
    .pull(pull),
    .db_in(db_in),
    .sync(sync),
    .int_ack(int_ack),
    .push_b(push_b),
    .irq_n(irq_n),
    .nmi_n(nmi_n),
`ifdef SO_PIN_EN
    .so_n(so_n),
`endif
    .p_out(p_out),
    .c(c),
    .d(d),
    .int_req(int_req),
    .nmi_sel(nmi_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk();
    stim_t s;
    s = '0;
    s.rstN = 1'b1;
    s.irqN = irqLvl;
    s.nmiN = nmiLvl;
    s.soN  = soLvl;
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs that were present at it.
  task automatic modelEdge();
    logic [7:0] newP;
    logic [7:0] owned;
    logic       nmiEdge, soEdge;
    int         opBit[8];
    logic       opVal[8];
    opBit = '{0, 0, 0, 2, 2, 3, 3, 6};
    opVal = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (!rst_n) begin
      mP = 8'h04;
      mIPoll = 1'b1;
      mNmiPend = 1'b0;
      irqHist = '{1'b1, 1'b1, 1'b1};
      nmiHist = '{1'b1, 1'b1, 1'b1};
      soHist  = '{1'b1, 1'b1, 1'b1};
      return;
    end
    nmiEdge = (nmiHist[1] == 1'b0) && (nmiHist[0] == 1'b1);
    soEdge  = (soHist[1] == 1'b0) && (soHist[0] == 1'b1);
    newP  = mP;
    owned = 8'h30;
    if (int_ack) begin
      newP[2] = 1'b1;
      owned[2] = 1'b1;
    end
    if (pull) begin
      newP  = (newP & owned) | (db_in & ~owned);
      owned = 8'hFF;
    end
    if (flag_op != 3'd0 && !owned[opBit[flag_op]]) begin
      newP[opBit[flag_op]] = opVal[flag_op];
      owned[opBit[flag_op]] = 1'b1;
    end
`ifdef SO_PIN_EN
    if (soEdge && !owned[6]) begin
      newP[6] = 1'b1;
      owned[6] = 1'b1;
    end
`endif
    if (upd_nz && !owned[7]) newP[7] = alu_n;
    if (upd_nz && !owned[1]) newP[1] = alu_z;
    if (upd_v && !owned[6]) newP[6] = alu_v;
    if (upd_c && !owned[0]) newP[0] = alu_c;
    if (pull) mIPoll = db_in[2];
    else if (sync) mIPoll = mP[2];
    if (nmiEdge) mNmiPend = 1'b1;
    else if (int_ack) mNmiPend = 1'b0;
    void'(irqHist.pop_front());
    irqHist.push_back(irq_n);
    void'(nmiHist.pop_front());
    nmiHist.push_back(nmi_n);
    void'(soHist.pop_front());
    soHist.push_back(so_n);
    mP = newP & 8'hCF;
  endtask

  // One cycle: step the model at the edge, drive new inputs, queue the expected outputs.
  task automatic applyStimulus(input stim_t s);
    logic [7:0] expP;
    logic       expReq;
    @(posedge clk);
    #1;
    cycleNo++;
    modelEdge();
    rst_n   = s.rstN;
    alu_n   = s.aluN;
    alu_v   = s.aluV;
    alu_z   = s.aluZ;
    alu_c   = s.aluC;
    upd_nz  = s.updNz;
    upd_v   = s.updV;
    upd_c   = s.updC;
    flag_op = s.flagOp;
    pull    = s.pull;
    db_in   = s.db;
    sync    = s.sync;
    int_ack = s.intAck;
    push_b  = s.pushB;
    irq_n   = s.irqN;
    nmi_n   = s.nmiN;
    so_n    = s.soN;
    expP    = mP | 8'h20 | (s.pushB ? 8'h10 : 8'h00);
    expReq  = mNmiPend | (!irqHist[1] && !mIPoll);
    expQ.push_back({expP, mP[0], mP[3], expReq, mNmiPend});
  endtask

  task automatic checkOutput(input logic [11:0] want, input logic [11:0] got);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL outputs cycle %0d: got p_out=%h c=%b d=%b int_req=%b nmi_sel=%b, want p_out=%h c=%b d=%b int_req=%b nmi_sel=%b",
               cycleNo, got[11:4], got[3], got[2], got[1], got[0],
               want[11:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  initial begin
    logic [11:0] want;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        want = expQ.pop_front();
        checkOutput(want, {p_out, c, d, int_req, nmi_sel});
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(mk());
  endtask

  initial begin
    stim_t s;
    irqLvl = 1'b1;
    nmiLvl = 1'b1;
    soLvl  = 1'b1;
    mP = 8'h00;
    mIPoll = 1'b0;
    mNmiPend = 1'b0;
    irqHist = '{1'b1, 1'b1, 1'b1};
    nmiHist = '{1'b1, 1'b1, 1'b1};
    soHist  = '{1'b1, 1'b1, 1'b1};
    s = mk();
    s.rstN = 1'b0;
    {rst_n, alu_n, alu_v, alu_z, alu_c, upd_nz, upd_v, upd_c} = 8'b0;
    flag_op = 3'd0;
    {pull, sync, int_ack, push_b} = 4'b0;
    db_in = 8'h00;
    {irq_n, nmi_n, so_n} = 3'b111;

    applyStimulus(s);
    applyStimulus(s);
    idle(1);
    s = mk(); s.pushB = 1'b1; applyStimulus(s);

    s = mk(); s.pull = 1'b1; s.db = 8'hFF; applyStimulus(s);
    idle(1);
    s = mk(); s.pull = 1'b1; s.db = 8'h00; applyStimulus(s);
    s = mk(); s.aluN = 1'b1; s.aluV = 1'b1; s.aluC = 1'b1;
    s.updNz = 1'b1; s.updC = 1'b1; s.flagOp = 3'd1; applyStimulus(s);
    idle(1);

    s = mk(); s.flagOp = 3'd4; s.sync = 1'b1; applyStimulus(s);
    s = mk(); s.sync = 1'b1; applyStimulus(s);
    irqLvl = 1'b0;
    idle(3);
    s = mk(); s.flagOp = 3'd3; applyStimulus(s);
    idle(2);
    s = mk(); s.sync = 1'b1; applyStimulus(s);
    idle(2);
    s = mk(); s.flagOp = 3'd4; s.sync = 1'b1; applyStimulus(s);
    s = mk(); s.sync = 1'b1; applyStimulus(s);
    irqLvl = 1'b1;
    idle(3);

    nmiLvl = 1'b0;
    idle(5);
    s = mk(); s.intAck = 1'b1; applyStimulus(s);
    idle(4);
    nmiLvl = 1'b1;
    idle(3);
    nmiLvl = 1'b0;
    idle(2);
    s = mk(); s.intAck = 1'b1; applyStimulus(s);
    idle(2);
    s = mk(); s.rstN = 1'b0; applyStimulus(s);
    idle(2);
    nmiLvl = 1'b1;
    idle(3);

`ifdef SO_PIN_EN
    soLvl = 1'b0;
    idle(2);
    s = mk(); s.updV = 1'b1; s.aluV = 1'b0; applyStimulus(s);
    idle(2);
    soLvl = 1'b1;
    idle(3);
`endif

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) irqLvl = ~irqLvl;
      if ($urandom_range(0, 11) == 0) nmiLvl = ~nmiLvl;
      if ($urandom_range(0, 11) == 0) soLvl = ~soLvl;
      s = mk();
      s.rstN   = ($urandom_range(0, 199) != 0);
      s.aluN   = 1'($urandom);
      s.aluV   = 1'($urandom);
      s.aluZ   = 1'($urandom);
      s.aluC   = 1'($urandom);
      s.updNz  = 1'($urandom);
      s.updV   = 1'($urandom);
      s.updC   = 1'($urandom);
      s.flagOp = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.pull   = ($urandom_range(0, 19) == 0);
      s.db     = 8'($urandom);
      s.sync   = ($urandom_range(0, 3) == 0);
      s.intAck = ($urandom_range(0, 15) == 0);
      s.pushB  = 1'($urandom);
      applyStimulus(s);
    end

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_flags.md
# status_flags

Processor status (P) register and interrupt front end for the 6502 core. It captures the N/V/Z/C flags produced by the ALU under per-instruction update strobes and executes the flag instructions (CLC/SEC, CLI/SEI, CLD/SED, CLV). It also handles PLP/RTI pulls and formats P for PHP/BRK/interrupt pushes. It synchronises irq_n/nmi_n, holds the NMI edge latch, and applies the 6502 one-instruction delay on I-flag masking; its `c` output feeds the ALU carry-in.

## Interface
- No parameters.
- `clk` in 1: core clock, all state rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `alu_n`, `alu_v`, `alu_z`, `alu_c` in 1 each: flag outputs of the ALU for the current cycle.
- `upd_nz` in 1: load N,Z from `alu_n`/`alu_z` this cycle.
- `upd_v` in 1: load V from `alu_v`.
- `upd_c` in 1: load C from `alu_c`.
- `flag_op` in 3: 0 NONE, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV.
- `pull` in 1: load P from `db_in` (PLP/RTI).
- `db_in` in 8: data bus value for `pull`.
- `sync` in 1: opcode-fetch cycle strobe (instruction boundary).
- `int_ack` in 1: interrupt sequence entered; sets I and clears the NMI latch.
- `push_b` in 1: value for bit 4 of `p_out` (1 for PHP/BRK, 0 for IRQ/NMI).
- `irq_n`, `nmi_n` in 1 each: asynchronous interrupt pins.
- `so_n` in 1: set-overflow pin (present only with SO_PIN_EN).
- `p_out` out 8: {N,V,1,push_b,D,I,Z,C}, combinational from registers.
- `c` out 1: C flag to ALU carry-in.
- `d` out 1: D flag.
- `int_req` out 1: interrupt pending at the next boundary.
- `nmi_sel` out 1: pending request is NMI (vector select).

## Operation
- P is stored as six flops: N, V, D, I, Z, C. Bits 5 and 4 are not stored. On `pull`, db_in[5:4] are ignored.
- Per-cycle priority, highest first:
  - `int_ack` sets I. Other flags still update from lower-priority sources.
  - `pull` loads all six flags and overrides `flag_op`, `upd_*` and SO.
  - `flag_op` drives its target flag. It overrides `upd_*` on the same flag.
  - SO edge sets V and overrides `upd_v`.
  - `upd_nz`/`upd_v`/`upd_c`.
- Any combination of `upd_*` strobes is legal in one cycle. Unstrobed flags hold.
- `irq_n`, `nmi_n` and `so_n` each pass through a 2-flop synchroniser (s1→s2), plus a third flop s3 for edge detection.
- NMI: when s2=0 and s3=1, `nmi_pend` is set. It stays set until `int_ack`. A new edge in the same cycle as `int_ack` wins: `nmi_pend` stays 1.
- `i_poll` is loaded from the registered I on every cycle with `sync`=1, taking the value before that cycle's update. `pull` additionally loads `i_poll` directly from db_in[2] (RTI semantics).
- `int_req` = nmi_pend | (~irq_s2 & ~i_poll).
- `nmi_sel` = nmi_pend.
- IRQ is level-sensitive and not latched.

## Timing
- Reset (`rst_n`=0 at an edge): N=V=Z=C=D=0, I=1, i_poll=1, nmi_pend=0, all synchroniser flops=1.
- After reset: `p_out`=0x24 with push_b=0 (0x34 with push_b=1); c=0, d=0, int_req=0, nmi_sel=0.
- Reset mid-interrupt discards any pending NMI.
- Flag updates are visible one cycle after the strobe edge.
- `nmi_n` first sampled low at edge k → nmi_pend=1 after edge k+2. A held-low `nmi_n` produces no second request.
- `irq_n` low sampled at edge k → irq_s2=0 after edge k+1. `int_req` then follows combinationally if i_poll=0.
- CLI/SEI delay: a `flag_op` at cycle t changes I after edge t. `i_poll` follows only at the next `sync` cycle edge. A pending IRQ therefore is not masked or unmasked until after the following instruction boundary.

## Configuration
- `SO_PIN_EN` defined: `so_n` port exists. A synchronised falling edge (s2=0, s3=1) sets V on the next edge, at the priority above.
- `SO_PIN_EN` undefined: no `so_n` port, no SO synchroniser; V changes only via `upd_v`, CLV and `pull`.

## Test plan
- Reset → `p_out`=0x24, int_req=0. Pulse pull with db_in=0xFF → `p_out`=0xEF (push_b=0), i_poll=1.
- alu_n=1, alu_z=0, alu_c=1, alu_v=1 with upd_nz+upd_c and flag_op=CLC in the same cycle → N=1, Z=0, C=0, V unchanged (0).
- irq_n held low, I=1: CLI at t, then sync at t+3 → int_req stays 0 through t+3 and rises after edge t+3.
- nmi_n falls at edge 10 and stays low → nmi_pend/int_req=1 after edge 12. int_ack at 15 → nmi_pend=0 and I=1 after edge 15, no re-trigger.
- New nmi edge coincident with int_ack → nmi_pend remains 1. rst_n=0 with nmi_pend=1 → nmi_pend=0, I=1.
- With SO_PIN_EN: so_n falls at edge 20 and upd_v with alu_v=0 at cycle 22 → V=1 after edge 22. Without the macro, V=0 and elaboration has no `so_n` port.
